extern_resp_unit: RTL and testbench

- Callee-side responder for a generated top level's extern call. The top level drives a 16-bit argument and expects an 8-bit result.
- This block is the device at the other end of that call. It accepts arguments over a valid/ready request channel and computes the result through a fixed-latency pipeline.
- Results wait in an output FIFO until consumed on a valid/ready response channel.
- Credit-based admission guarantees no result is dropped under backpressure.

---
 rtl/extern_resp_pkg.sv | 14 +
 rtl/extern_resp_fifo.sv | 44 ++++
 rtl/extern_resp_unit.sv | 55 +++++
 tb/tb_extern_resp_unit.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/extern_resp_pkg.sv
// extern_resp_pkg: shared widths, pipeline stage type and the call's arithmetic.
package extern_resp_pkg;
  localparam int RES_W = 8;
  localparam int ARG_W = 16;
  typedef struct packed {
    logic             valid;
    logic [RES_W-1:0] data;
  } stage_t;
  function automatic logic [RES_W-1:0] call_sum(input logic [ARG_W-1:0] a, input logic sat);
    logic [RES_W:0] s;
    s = {1'b0, a[ARG_W-1:RES_W]} + {1'b0, a[RES_W-1:0]};
    return (sat && s[RES_W]) ? {RES_W{1'b1}} : s[RES_W-1:0];
  endfunction
endpackage

// File: rtl/extern_resp_fifo.sv
// extern_resp_fifo: result FIFO whose head entry is held in its own register.
module extern_resp_fifo
  import extern_resp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [RES_W-1:0]       data_i,
  output logic [RES_W-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [RES_W-1:0] mem_q [DEPTH];
  logic [RES_W-1:0] head_q, head_d;
  logic [AW:0]      wr_q, rd_q, wr_d, rd_d, cnt_d;
  logic [AW-1:0]    rd_nxt;
  logic             pop;
  assign count_o = wr_q - rd_q;
  assign pop     = pop_i && (count_o != '0);
  assign wr_d    = wr_q + (AW+1)'(push_i);
  assign rd_d    = rd_q + (AW+1)'(pop);
  assign cnt_d   = wr_d - rd_d;
  assign rd_nxt  = rd_q[AW-1:0] + AW'(1);
  // The head register takes the incoming word whenever it becomes the oldest entry.
  always_comb head_d = (cnt_d == '0) ? '0
                     : (count_o == '0 || (pop && count_o == (AW+1)'(1))) ? data_i
                     : pop ? mem_q[rd_nxt] : head_q;
  always_ff @(posedge clk) if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
    end
  end
  assign head_o = head_q;
endmodule

// File: rtl/extern_resp_unit.sv
// extern_resp_unit: callee for an extern call, fixed-latency sum pipeline with
// credit-protected result FIFO.
module extern_resp_unit
  import extern_resp_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4,
  parameter int SAT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ARG_W-1:0] x,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [RES_W-1:0] out,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  stage_t [LATENCY-1:0] st_q, st_d;
  logic [AW:0]          occ_q, occ_d, fifo_cnt;
  logic                 en_q, acc, pop;
  // Credits cover pipeline plus FIFO, so a full FIFO can never be overrun.
  assign req_ready  = en_q && (occ_q < (AW+1)'(DEPTH));
  assign acc        = req_valid && req_ready;
  assign resp_valid = fifo_cnt != '0;
  assign pop        = resp_valid && resp_ready;
  assign busy       = occ_q != '0;
  assign occ_d      = occ_q + (AW+1)'(acc) - (AW+1)'(pop);
  always_comb begin
    st_d[0] = '{valid: acc, data: acc ? call_sum(x, SAT != 0) : '0};
    for (int i = 1; i < LATENCY; i++) st_d[i] = st_q[i-1];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= '0;
      occ_q <= '0;
      en_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      occ_q <= occ_d;
      en_q  <= 1'b1;
    end
  end
  extern_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (st_q[LATENCY-1].valid),
    .pop_i  (resp_ready),
    .data_i (st_q[LATENCY-1].data),
    .head_o (out),
    .count_o(fifo_cnt)
  );
endmodule

// File: tb/tb_extern_resp_unit.sv
// tb_extern_resp_unit: directed checks of a modulo and a saturating instance.
module tb_extern_resp_unit;
  logic        clk = 1'b0, rst = 1'b0, req_valid = 1'b0, resp_ready = 1'b0;
  logic [15:0] x = '0;
  logic        rr0, rv0, bz0, rr1, rv1, bz1;
  logic [7:0]  o0, o1;
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  extern_resp_unit #(.LATENCY(2), .DEPTH(4), .SAT(0)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr0), .x(x),
    .resp_valid(rv0), .resp_ready(resp_ready), .out(o0), .busy(bz0));
  extern_resp_unit #(.LATENCY(2), .DEPTH(4), .SAT(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr1), .x(x),
    .resp_valid(rv1), .resp_ready(resp_ready), .out(o1), .busy(bz1));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    repeat (3) tick;
    tests++; if (rr0 !== 1'b0) begin fails++; $display("FAIL rst_req_ready: got %b want 0", rr0); end
    tests++; if (rv0 !== 1'b0) begin fails++; $display("FAIL rst_resp_valid: got %b want 0", rv0); end
    tests++; if (o0 !== 8'h00) begin fails++; $display("FAIL rst_out: got %h want 00", o0); end
    tests++; if (bz0 !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", bz0); end
    rst = 1'b1;
    #1;
    tests++; if (rr0 !== 1'b0) begin fails++; $display("FAIL rel_ready_early: got %b want 0", rr0); end
    tick;
    tests++; if (rr0 !== 1'b1) begin fails++; $display("FAIL rel_ready: got %b want 1", rr0); end
    tests++; if (rv0 !== 1'b0 || bz0 !== 1'b0 || o0 !== 8'h00) begin fails++; $display("FAIL rel_idle: rv=%b busy=%b out=%h want 0 0 00", rv0, bz0, o0); end
  endtask

  task automatic test_single;
    x = 16'h1234; req_valid = 1'b1;
    tick;
    req_valid = 1'b0; x = 16'hdead;
    tests++; if (bz0 !== 1'b1) begin fails++; $display("FAIL single_busy: got %b want 1", bz0); end
    tests++; if (rv0 !== 1'b0) begin fails++; $display("FAIL single_early1: got %b want 0", rv0); end
    tick;
    tests++; if (rv0 !== 1'b0) begin fails++; $display("FAIL single_early2: got %b want 0", rv0); end
    tick;
    tests++; if (rv0 !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", rv0); end
    tests++; if (o0 !== 8'h46) begin fails++; $display("FAIL single_out: got %h want 46", o0); end
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    tests++; if (rv0 !== 1'b0) begin fails++; $display("FAIL single_popped: got %b want 0", rv0); end
    tests++; if (bz0 !== 1'b0) begin fails++; $display("FAIL single_idle: got %b want 0", bz0); end
  endtask

  task automatic test_wrap_sat;
    logic [15:0] xs [3];
    logic [7:0]  e0 [3];
    logic [7:0]  e1 [3];
    xs = '{16'hFF01, 16'h8080, 16'h0000};
    e0 = '{8'h00, 8'h00, 8'h00};
    e1 = '{8'hFF, 8'hFF, 8'h00};
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x = xs[i];
      tick;
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests++; if (rv0 !== 1'b1 || rv1 !== 1'b1) begin fails++; $display("FAIL ws_valid%0d: got %b %b want 1 1", i, rv0, rv1); end
      tests++; if (o0 !== e0[i]) begin fails++; $display("FAIL wrap%0d: got %h want %h", i, o0, e0[i]); end
      tests++; if (o1 !== e1[i]) begin fails++; $display("FAIL sat%0d: got %h want %h", i, o1, e1[i]); end
      tick;
    end
    resp_ready = 1'b0;
    tests++; if (rv0 !== 1'b0 || rv1 !== 1'b0) begin fails++; $display("FAIL ws_empty: got %b %b want 0 0", rv0, rv1); end
  endtask

  task automatic test_backpressure;
    int         n;
    logic [7:0] k;
    n = 0; k = 8'h01;
    resp_ready = 1'b0; req_valid = 1'b1; x = {k, k};
    repeat (8) begin
      if (rr0) begin n++; k++; end
      tick;
      x = {k, k};
    end
    tests++; if (n !== 4) begin fails++; $display("FAIL bp_accepts: got %0d want 4", n); end
    tests++; if (rr0 !== 1'b0) begin fails++; $display("FAIL bp_ready: got %b want 0", rr0); end
    tests++; if (rv0 !== 1'b1 || o0 !== 8'h02) begin fails++; $display("FAIL bp_head: rv=%b out=%h want 1 02", rv0, o0); end
    tick;
    tests++; if (rv0 !== 1'b1 || o0 !== 8'h02 || rr0 !== 1'b0) begin fails++; $display("FAIL bp_stable: rv=%b out=%h rdy=%b want 1 02 0", rv0, o0, rr0); end
    req_valid = 1'b0; resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (o0 !== 8'(2 * (i + 1))) begin fails++; $display("FAIL bp_drain%0d: got %h want %h", i, o0, 8'(2 * (i + 1))); end
      tick;
      if (i == 0) begin
        tests++; if (rr0 !== 1'b1) begin fails++; $display("FAIL bp_credit: got %b want 1", rr0); end
      end
    end
    resp_ready = 1'b0;
    tests++; if (rv0 !== 1'b0 || bz0 !== 1'b0) begin fails++; $display("FAIL bp_idle: rv=%b busy=%b want 0 0", rv0, bz0); end
  endtask

  task automatic test_back_to_back_full;
    resp_ready = 1'b0; req_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      x = 16'(k);
      tick;
    end
    req_valid = 1'b0;
    tick;
    tick;
    tests++; if (rr0 !== 1'b0 || bz0 !== 1'b1 || o0 !== 8'h01) begin fails++; $display("FAIL full_state: rdy=%b busy=%b out=%h want 0 1 01", rr0, bz0, o0); end
    req_valid = 1'b1; x = 16'h0005; resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    tests++; if (o0 !== 8'h02) begin fails++; $display("FAIL full_pop: got %h want 02", o0); end
    tests++; if (rr0 !== 1'b1) begin fails++; $display("FAIL full_credit: got %b want 1", rr0); end
    tick;
    req_valid = 1'b0;
    tests++; if (rr0 !== 1'b0 || bz0 !== 1'b1) begin fails++; $display("FAIL full_refill: rdy=%b busy=%b want 0 1", rr0, bz0); end
    tick;
    tick;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (o0 !== 8'(i + 2)) begin fails++; $display("FAIL full_order%0d: got %h want %h", i, o0, 8'(i + 2)); end
      tick;
    end
    resp_ready = 1'b0;
    tests++; if (bz0 !== 1'b0) begin fails++; $display("FAIL full_idle: got %b want 0", bz0); end
  endtask

  task automatic test_reset_midflight;
    resp_ready = 1'b0; req_valid = 1'b1;
    x = 16'h0101; tick;
    x = 16'h0202; tick;
    x = 16'h0303; tick;
    req_valid = 1'b0;
    tests++; if (rv0 !== 1'b1) begin fails++; $display("FAIL mid_head: got %b want 1", rv0); end
    #2 rst = 1'b0;
    #1;
    tests++; if (rv0 !== 1'b0 || bz0 !== 1'b0 || rr0 !== 1'b0 || o0 !== 8'h00) begin fails++; $display("FAIL mid_async: rv=%b busy=%b rdy=%b out=%h want 0 0 0 00", rv0, bz0, rr0, o0); end
    @(negedge clk);
    rst = 1'b1;
    repeat (6) begin
      tick;
      tests++; if (rv0 !== 1'b0) begin fails++; $display("FAIL mid_stale: got %b want 0", rv0); end
    end
    tests++; if (bz0 !== 1'b0 || rr0 !== 1'b1) begin fails++; $display("FAIL mid_after: busy=%b rdy=%b want 0 1", bz0, rr0); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_wrap_sat;
    test_backpressure;
    test_back_to_back_full;
    test_reset_midflight;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
